// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of the SPI byte engine: fetches TX bytes from the transfer
// buffer, issues one engine start per byte and writes received bytes back to the buffer.
module spi_burst_ctrl #(
    parameter int          ADDR_W = 9,
    parameter logic [7:0]  FILL   = 8'hFF
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Go,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] Length,
    input  logic [1:0]        Mode,
    input  logic              HoldCS,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W:0]   BytesDone,
    output logic [ADDR_W-1:0] BufAddr,
    input  logic [7:0]        BufRdData,
    output logic              BufWrEn,
    output logic [7:0]        BufWrData,
    output logic              SpiStart,
    output logic [7:0]        SpiDataOut,
    output logic              SpiKeepCS,
    input  logic              SpiBusy,
    input  logic [7:0]        SpiDataIn
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ARM,
        S_WAIT,
        S_STORE
    } state_t;

    localparam logic [1:0] MODE_TX_ONLY = 2'b01;
    localparam logic [1:0] MODE_RX_ONLY = 2'b10;

    state_t              state_q;
    logic [ADDR_W-1:0]   len_q;
    logic [1:0]          mode_q;
    logic                hold_q;
    logic                abort_q;
    logic                last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     bytes_q;
    logic                busy_q;
    logic                done_q;
    logic                wr_en_q;
    logic [7:0]          wr_data_q;
    logic                start_q;
    logic [7:0]          dout_q;
    logic                keep_q;
    logic                is_last_d;

    // The byte entering LOAD is the last one if it is the final index or an abort is
    // pending (including one arriving in this very cycle).
    always_comb begin
        is_last_d = (addr_q == len_q) || abort_q || Abort;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            mode_q    <= 2'b00;
            hold_q    <= 1'b0;
            abort_q   <= 1'b0;
            last_q    <= 1'b0;
            addr_q    <= '0;
            bytes_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 8'h00;
            start_q   <= 1'b0;
            dout_q    <= 8'h00;
            keep_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (Abort && (state_q != S_IDLE)) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (Go) begin
                        len_q   <= Length;
                        mode_q  <= Mode;
                        hold_q  <= HoldCS;
                        addr_q  <= '0;
                        bytes_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    dout_q  <= (mode_q == MODE_RX_ONLY) ? FILL : BufRdData;
                    keep_q  <= is_last_d ? hold_q : 1'b1;
                    last_q  <= is_last_d;
                    start_q <= 1'b1;
                    state_q <= S_ARM;
                end
                S_ARM: begin
                    if (SpiBusy) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!SpiBusy) begin
                        wr_en_q   <= (mode_q != MODE_TX_ONLY);
                        wr_data_q <= SpiDataIn;
                        state_q   <= S_STORE;
                    end
                end
                S_STORE: begin
                    bytes_q <= bytes_q + (ADDR_W+1)'(1);
                    if (last_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        abort_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign BytesDone  = bytes_q;
    assign BufAddr    = addr_q;
    assign BufWrEn    = wr_en_q;
    assign BufWrData  = wr_data_q;
    assign SpiStart   = start_q;
    assign SpiDataOut = dout_q;
    assign SpiKeepCS  = keep_q;

endmodule
